// File: rtl/bcd_display_scan.sv
// bcd_display_scan: frame-synchronous 3-digit common-anode 7-segment scanner with blanking gaps
// Optional leading-zero blanking is enabled by defining BCD_LZB_EN.
module bcd_display_scan #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] unidades,
    input  logic [3:0] decenas,
    input  logic [3:0] centenas,
    input  logic       actualizar,
    output logic [2:0] an,
    output logic [6:0] seg,
    output logic       frame_start
);
    localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] R_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] B_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    typedef enum logic {SHOW, GAP} state_t;

    state_t      st;
    logic [1:0]  idx;
    logic [CW-1:0] cnt;
    logic [11:0] shadow, disp;
    logic        show_end, to_gap, to_next, boundary, blank, lit;
    logic [1:0]  idx_nx;
    logic [3:0]  nib;
    logic [11:0] live;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0: decode = 7'h40;
            4'd1: decode = 7'h79;
            4'd2: decode = 7'h24;
            4'd3: decode = 7'h30;
            4'd4: decode = 7'h19;
            4'd5: decode = 7'h12;
            4'd6: decode = 7'h02;
            4'd7: decode = 7'h78;
            4'd8: decode = 7'h00;
            4'd9: decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    // Slot sequencing and the current digit's lit/blank decision
    always_comb begin
        live     = {centenas, decenas, unidades};
        show_end = (st == SHOW) && (cnt == R_LAST);
        to_gap   = show_end && (BLANK_CYCLES != 0);
        to_next  = ((st == GAP) && (cnt == B_LAST)) || (show_end && (BLANK_CYCLES == 0));
        idx_nx   = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        boundary = to_next && (idx == 2'd2);
        nib      = (idx == 2'd0) ? disp[3:0] : (idx == 2'd1) ? disp[7:4] : disp[11:8];
`ifdef BCD_LZB_EN
        blank    = ((idx == 2'd2) && (disp[11:8] == 4'd0)) || ((idx == 2'd1) && (disp[11:4] == 8'd0));
`else
        blank    = 1'b0;
`endif
        lit      = (st == SHOW) && !blank;
    end

    // Scan FSM, digit registers and registered display outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= SHOW;
            idx         <= 2'd0;
            cnt         <= '0;
            shadow      <= '0;
            disp        <= '0;
            an          <= 3'b111;
            seg         <= 7'h7F;
            frame_start <= 1'b0;
        end else begin
            if (to_gap) begin
                st  <= GAP;
                cnt <= '0;
            end else if (to_next) begin
                st  <= SHOW;
                idx <= idx_nx;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (actualizar) shadow <= live;
            if (boundary) disp <= actualizar ? live : shadow;
            an          <= lit ? ~(3'b001 << idx) : 3'b111;
            seg         <= lit ? decode(nib) : 7'h7F;
            frame_start <= (st == SHOW) && (idx == 2'd0) && (cnt == '0);
        end
    end
endmodule

// File: tb/tb_bcd_display_scan.sv
// tb_bcd_display_scan: randomized scan check against a frame-position model of the display
module tb_bcd_display_scan;
    localparam int R = 4;
    localparam int B = 2;
    localparam int P = R + B;
    localparam int F = 3 * P;
`ifdef BCD_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] u = 4'd0, d = 4'd0, c = 4'd0;
    logic act = 1'b0;
    logic [2:0] an;
    logic [6:0] seg;
    logic fs;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcd_display_scan #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
        .clk(clk), .rst_n(rst_n), .unidades(u), .decenas(d), .centenas(c),
        .actualizar(act), .an(an), .seg(seg), .frame_start(fs)
    );

    logic [6:0] dec_t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    int n, p, s;
    logic [11:0] sh_m, dp_m;
    logic [3:0] dg;
    logic bl;
    logic [2:0] e_an = 3'b111;
    logic [6:0] e_seg = 7'h7F;
    logic e_fs = 1'b0;

    task automatic chk(input string name, input logic [6:0] a, input logic [6:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, a, e, $time);
        end
    endtask

    // Model: output after edge n is the picture at frame position (n-1) mod F
    always @(posedge clk) begin
        if (!rst_n) begin
            n = 0; sh_m = '0; dp_m = '0;
            e_an = 3'b111; e_seg = 7'h7F; e_fs = 1'b0;
        end else begin
            p = n % F;
            s = p / P;
            dg = dp_m[s*4 +: 4];
            bl = LZB && ((s == 2 && dp_m[11:8] == 4'd0) || (s == 1 && dp_m[11:4] == 8'd0));
            if ((p % P) < R && !bl) begin
                e_an = 3'b111;
                e_an[s] = 1'b0;
                e_seg = dec_t[dg];
            end else begin
                e_an = 3'b111;
                e_seg = 7'h7F;
            end
            e_fs = (p == 0);
            n++;
            if (n % F == 0) dp_m = act ? {c, d, u} : sh_m;
            if (act) sh_m = {c, d, u};
        end
    end

    // Every-cycle comparison against the model (idle picture while in reset)
    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_an", 7'(an), 7'(e_an));
            chk("model_seg", seg, e_seg);
            chk("model_fs", 7'(fs), 7'(e_fs));
        end else begin
            chk("rst_an", 7'(an), 7'h7);
            chk("rst_seg", seg, 7'h7F);
            chk("rst_fs", 7'(fs), 7'h0);
        end
    end

    task automatic wait_fs;
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!fs && k < 40);
        chk("fs_timeout", 7'(fs), 7'h1);
    endtask

    task automatic strobe(input logic [3:0] hc, input logic [3:0] hd, input logic [3:0] hu);
        c = hc; d = hd; u = hu; act = 1'b1;
        @(negedge clk);
        act = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_an", 7'(an), 7'h6);
        chk("first_seg", seg, 7'h40);
        chk("first_fs", 7'(fs), 7'h1);
        repeat (3) @(negedge clk);
        chk("slot0_last_an", 7'(an), 7'h6);
        @(negedge clk);
        chk("gap_an", 7'(an), 7'h7);
        chk("gap_seg", seg, 7'h7F);
        repeat (2) @(negedge clk);
        chk("slot1_an", 7'(an), LZB ? 7'h7 : 7'h5);
        chk("slot1_fs", 7'(fs), 7'h0);
        repeat (12) @(negedge clk);
        chk("frame2_fs", 7'(fs), 7'h1);
        chk("frame2_an", 7'(an), 7'h6);
        // Mid-frame update: old digits hold until the next frame
        repeat (3) @(negedge clk);
        strobe(4'd9, 4'd8, 4'd7);
        repeat (2) @(negedge clk);
        chk("hold_seg", seg, LZB ? 7'h7F : 7'h40);
        wait_fs;
        chk("upd_units", seg, 7'h78);
        repeat (6) @(negedge clk);
        chk("upd_tens_an", 7'(an), 7'h5);
        chk("upd_tens", seg, 7'h00);
        repeat (6) @(negedge clk);
        chk("upd_hund_an", 7'(an), 7'h3);
        chk("upd_hund", seg, 7'h10);
        // Strobe coincident with the frame boundary uses the live inputs
        repeat (F - 2 - 12) @(negedge clk);
        strobe(4'd1, 4'd2, 4'd3);
        @(negedge clk);
        chk("bypass_fs", 7'(fs), 7'h1);
        chk("bypass_units", seg, 7'h30);
        repeat (6) @(negedge clk);
        chk("bypass_tens", seg, 7'h24);
        repeat (6) @(negedge clk);
        chk("bypass_hund", seg, 7'h79);
        // Invalid BCD in the units digit
        strobe(4'd6, 4'd4, 4'hC);
        wait_fs;
        chk("inv_units", seg, 7'h3F);
        repeat (6) @(negedge clk);
        chk("inv_tens", seg, 7'h19);
        repeat (6) @(negedge clk);
        chk("inv_hund", seg, 7'h02);
        // Leading zeros
        strobe(4'd0, 4'd0, 4'd5);
        wait_fs;
        chk("lz_units_an", 7'(an), 7'h6);
        chk("lz_units", seg, 7'h12);
        repeat (6) @(negedge clk);
        chk("lz_tens_an", 7'(an), LZB ? 7'h7 : 7'h5);
        chk("lz_tens", seg, LZB ? 7'h7F : 7'h40);
        repeat (6) @(negedge clk);
        chk("lz_hund_an", 7'(an), LZB ? 7'h7 : 7'h3);
        chk("lz_hund", seg, LZB ? 7'h7F : 7'h40);
        // Randomized traffic against the model
        repeat (900) begin
            @(negedge clk);
            c = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            d = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            u = 4'($urandom_range(0, 15));
            act = ($urandom_range(0, 9) == 0);
        end
        @(negedge clk);
        act = 1'b0;
        // Asynchronous reset while tens digit slot is showing
        wait_fs;
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_an", 7'(an), 7'h7);
        chk("async_seg", seg, 7'h7F);
        chk("async_fs", 7'(fs), 7'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_fs;
        chk("restart_an", 7'(an), 7'h6);
        chk("restart_seg", seg, 7'h40);
        repeat (6) @(negedge clk);
        chk("restart_tens", seg, LZB ? 7'h7F : 7'h40);
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bcd_display_scan.md
# bcd_display_scan

- Downstream stage of the 3-digit BCD subtractor: consumes its `unidades`, `decenas` and `centenas` digit outputs.
- Drives a multiplexed, common-anode, 3-digit 7-segment display.
- Snapshots the digits on an update strobe and applies them only at frame boundaries, so the display never tears.
- Scans the digits with a programmable on-time and an inter-digit blanking gap to suppress ghosting.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit is lit; legal range ≥1.
- `BLANK_CYCLES`, default 4: cycles with all anodes off between digits; 0 means no gap.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `unidades`, input, 4: BCD units digit from the subtractor.
- `decenas`, input, 4: BCD tens digit.
- `centenas`, input, 4: BCD hundreds digit.
- `actualizar`, input, 1: update strobe; samples the three digit inputs into the shadow register.
- `an`, output, 3: active-low anodes; bit 0 = units, bit 1 = tens, bit 2 = hundreds.
- `seg`, output, 7: active-low segments, order {g,f,e,d,c,b,a}.
- `frame_start`, output, 1: one-cycle pulse when digit 0 begins a new frame.

## Operation
- **Registers**
  - `shadow` (12 bits): loads {centenas, decenas, unidades} on any clock edge where `actualizar` = 1.
  - `disp` (12 bits): loads `shadow` at each frame boundary.
  - Frame boundary is the transition GAP(2) → SHOW(0), or SHOW(2) → SHOW(0) when `BLANK_CYCLES` = 0.
  - If `actualizar` is high in the same cycle as a boundary, `disp` takes the live inputs directly (bypass).
- **State machine**
  - States: SHOW and GAP.
  - Digit index `idx` ∈ {0,1,2}; cycle counter `cnt`.
  - SHOW(idx): lasts `REFRESH_DIV` cycles. Then GAP(idx), or SHOW(idx+1 mod 3) if `BLANK_CYCLES` = 0.
  - GAP(idx): lasts `BLANK_CYCLES` cycles, then SHOW(idx+1 mod 3).
  - `idx` wraps 2 → 0. Frame length is 3·(`REFRESH_DIV` + `BLANK_CYCLES`) cycles.
- **Decode (active-low, gfedcba)**

| Digit | Pattern |
|---|---|
| 0 | 7'h40 |
| 1 | 7'h79 |
| 2 | 7'h24 |
| 3 | 7'h30 |
| 4 | 7'h19 |
| 5 | 7'h12 |
| 6 | 7'h02 |
| 7 | 7'h78 |
| 8 | 7'h00 |
| 9 | 7'h10 |
| 10–15 (invalid BCD) | 7'h3F (dash, segment g only) |

- **Outputs**
  - In SHOW(idx): `an` has only bit idx low; `seg` = decode of `disp` nibble idx.
  - In GAP: `an` = 3'b111 and `seg` = 7'h7F.
- **Reset** (`rst_n` low, asynchronous, takes effect immediately, including mid-frame):
  - `an` = 3'b111, `seg` = 7'h7F, `frame_start` = 0.
  - `shadow` = `disp` = 0; state = SHOW, `idx` = 0, `cnt` = 0.

## Timing
- All outputs are registered: they reflect the state of the previous cycle (1-cycle latency).
- First edge after `rst_n` deasserts: `an` = 3'b110, `seg` = 7'h40, `frame_start` = 1.
- `frame_start` pulses in the same cycle `an` first shows digit 0 of each frame, using the new `disp`.
- Latency from `actualizar` to visible change is ≤ one frame + 1 cycle.
- `disp` never changes in the middle of a frame.
- Anodes of two different digits are never low in the same cycle, including at `BLANK_CYCLES` = 0.

## Configuration
- Macro: `BCD_LZB_EN`.
- **Defined** (leading-zero blanking):
  - Hundreds digit is blanked when `disp` hundreds = 0.
  - Tens digit is blanked when `disp` hundreds = 0 and `disp` tens = 0.
  - A blanked slot keeps its timing, but its anode stays high and `seg` = 7'h7F.
  - Units digit is never blanked.
- **Not defined**: all three digits always display, zeros included.

## Test plan
All scenarios use `REFRESH_DIV` = 4, `BLANK_CYCLES` = 2.
- **Reset/first frame:** release reset with `disp` = 0.
  - Expect `an` = 110 for 4 cycles, then 111 for 2 cycles, then 101, and so on.
  - `seg` = 7'h40 in every lit slot; `frame_start` every 18 cycles.
- **Update at boundary:** pulse `actualizar` mid-frame with inputs 9/8/7 (hundreds/tens/units).
  - Old values hold until the next `frame_start`.
  - Then the slots show 7'h78 (units), 7'h00 (tens), 7'h10 (hundreds).
- **Coincident strobe:** assert `actualizar` with 1/2/3 exactly on the boundary cycle.
  - The new frame shows 3/2/1 immediately; there is no stale frame.
- **Invalid BCD:** units = 4'hC → units slot `seg` = 7'h3F; other digits are unaffected.
- **Leading-zero blanking:** inputs 0/0/5.
  - With `BCD_LZB_EN`: only `an` = 110 ever goes low.
  - Without it: all three anodes cycle, showing 7'h40, 7'h40, 7'h12.
- **Async reset mid-SHOW(1):** drop `rst_n` between clock edges.
  - Expect `an` = 111 and `seg` = 7'h7F immediately.
  - After release, the scan restarts at digit 0 with `disp` = 0.
